// File: rtl/ex_forward_ctrl.sv
// EX operand forwarding selects (1-cycle latency from ID) and combinational load-use stall.
// No handshake: a stall or flush turns the instruction entering EX into a bubble.
module ex_forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] IdRs,
  input  logic [REG_ADDR_W-1:0] IdRt,
  input  logic                  IdUsesRs,
  input  logic                  IdUsesRt,
  input  logic [REG_ADDR_W-1:0] IdDest,
  input  logic                  IdRegWrite,
  input  logic                  IdMemRead,
  input  logic                  Flush,
  output logic [1:0]            FwdA,
  output logic [1:0]            FwdB,
  output logic                  Stall,
  output logic [CNT_W-1:0]      StallCount
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // WB needs no shadow: the register file's write-before-read covers that distance.
  logic [REG_ADDR_W-1:0] r_ex_dest;
  logic                  r_ex_rw;
  logic                  r_ex_mr;
  logic [REG_ADDR_W-1:0] r_mem_dest;
  logic                  r_mem_rw;
  logic [1:0]            r_fwd_a;
  logic [1:0]            r_fwd_b;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic                  w_rs_hit_ex;
  logic                  w_rt_hit_ex;
  logic                  w_stall;
  logic                  w_bubble;
  logic [1:0]            w_sel_a;
  logic [1:0]            w_sel_b;

  function automatic logic [1:0] fwd_sel(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  ex_rw,
    input logic [REG_ADDR_W-1:0] ex_dest,
    input logic                  mem_rw,
    input logic [REG_ADDR_W-1:0] mem_dest
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (uses && (src != '0)) begin
      if (ex_rw && (ex_dest == src)) begin
        sel = SEL_MEM;
      end else if (mem_rw && (mem_dest == src)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  assign w_rs_hit_ex = IdUsesRs && (IdRs == r_ex_dest);
  assign w_rt_hit_ex = IdUsesRt && (IdRt == r_ex_dest);
  assign w_stall     = !Flush && r_ex_mr && r_ex_rw && (r_ex_dest != '0) &&
                       (w_rs_hit_ex || w_rt_hit_ex);
  assign w_bubble    = w_stall || Flush;

  assign w_sel_a = fwd_sel(IdUsesRs, IdRs, r_ex_rw, r_ex_dest, r_mem_rw, r_mem_dest);
  assign w_sel_b = fwd_sel(IdUsesRt, IdRt, r_ex_rw, r_ex_dest, r_mem_rw, r_mem_dest);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ex_dest  <= '0;
      r_ex_rw    <= 1'b0;
      r_ex_mr    <= 1'b0;
      r_mem_dest <= '0;
      r_mem_rw   <= 1'b0;
      r_fwd_a    <= SEL_RF;
      r_fwd_b    <= SEL_RF;
    end else begin
      r_mem_dest <= r_ex_dest;
      r_mem_rw   <= r_ex_rw;
      if (w_bubble) begin
        r_ex_dest <= '0;
        r_ex_rw   <= 1'b0;
        r_ex_mr   <= 1'b0;
        r_fwd_a   <= SEL_RF;
        r_fwd_b   <= SEL_RF;
      end else begin
        r_ex_dest <= IdDest;
        r_ex_rw   <= IdRegWrite;
        r_ex_mr   <= IdMemRead;
        r_fwd_a   <= w_sel_a;
        r_fwd_b   <= w_sel_b;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign FwdA       = r_fwd_a;
  assign FwdB       = r_fwd_b;
  assign Stall      = w_stall;
  assign StallCount = r_stall_cnt;

endmodule
